// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one sum bit per RUN cycle, LSB first, with registered
// sum/carry/overflow results published only on the final RUN edge.
module serial_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic [1:0]   o_dbg_state
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: start is a level request honoured only in IDLE; done is a
  // one-cycle strobe in DONE, busy is high exactly in RUN; there is no ready.

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic          w_s;
  logic          w_c;
  logic [N-1:0]  w_shift_next;
  logic          w_last;

  assign w_s          = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c          = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_shift_next = {w_s, r_shift[N-1:1]};
  assign w_last       = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_shift <= w_shift_next;
          if (w_last) begin
            // r_carry here is the carry into bit N-1, w_c the carry out of it
            r_sum   <= w_shift_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule
